// File: rtl/vga_fb_scanout_reader_pkg.sv
// Shared types and defaults for the VGA frame-buffer scan-out reader.
// Holds the pixel type, frame geometry defaults and FSM state encodings.
package vga_pkg;

    typedef logic [15:0] rgb565_t;

    localparam int PIXELS_PER_WORD = 2;

    localparam int DEF_WIDTH      = 320;
    localparam int DEF_HEIGHT     = 240;
    localparam int DEF_BASE_ADDR  = 0;
    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;

    function automatic int words_per_frame(input int width, input int height);
        return (width * height) / PIXELS_PER_WORD;
    endfunction

endpackage

// File: rtl/vga_fb_scanout_reader_if.sv
// Bus bundle between the scan-out reader, the frame memory and the pixel sink.
// master = the reader; slave = memory plus downstream VGA pipeline.
interface vga_fb_scanout_reader_if #(
    parameter int ADDR_W = 16
);
    import vga_pkg::*;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic              mem_clken;
    logic [31:0]       mem_readdata;

    rgb565_t           px_data;
    logic              px_valid;
    logic              px_ready;
    logic              px_sop;
    logic              px_eop;

    modport master (
        output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
        input  mem_readdata,
        output px_data, px_valid, px_sop, px_eop,
        input  px_ready
    );

    modport slave (
        input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
        output mem_readdata,
        input  px_data, px_valid, px_sop, px_eop,
        output px_ready
    );

endinterface

// File: rtl/vga_fb_scanout_reader_word_fifo.sv
// Synchronous show-ahead word FIFO; the head entry is visible without a pop.
// Overflow is prevented upstream by the credit check, so push is not gated.
module vga_fb_word_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              do_pop;

    assign do_pop = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_i, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/vga_fb_scanout_reader.sv
// Frame-buffer scan-out: reads one frame linearly from frame memory and
// unpacks two RGB565 pixels per word into an SOP/EOP-framed pixel stream.
//   state    | meaning
//   IDLE     | waiting for enable, no reads
//   RUN      | issuing reads while FIFO credit remains
//   DRAIN    | all words issued, waiting for the EOP transfer
module vga_fb_scanout_reader
    import vga_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int HEIGHT     = DEF_HEIGHT,
    parameter int BASE_ADDR  = DEF_BASE_ADDR,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    vga_fb_scanout_reader_if.master   bus,
    output logic                      frame_done
);
    localparam int PIXELS = WIDTH * HEIGHT;
    localparam int WORDS  = words_per_frame(WIDTH, HEIGHT);
    localparam int PCNT_W = $clog2(PIXELS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);
    localparam logic [PCNT_W-1:0] LAST_PIX  = PCNT_W'(PIXELS - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  wcnt_q, wcnt_d;
    logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
    logic               half_q, half_d;
    logic               inflight_q;
    logic               frame_done_q, frame_done_d;

    logic [31:0]        fifo_head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty;
    logic               issue;
    logic               xfer;
    logic               pop;
    logic               eop_xfer;

    // Credit counts the word still on its way back from memory.
    assign issue    = (state_q == ST_RUN) &&
                      ((fifo_count + CNT_W'(inflight_q)) < DEPTH_C);
    assign xfer     = !fifo_empty && bus.px_ready;
    assign pop      = xfer && half_q;
    assign eop_xfer = xfer && (pcnt_q == LAST_PIX);

    vga_fb_word_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (32)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (inflight_q),
        .wdata_i (bus.mem_readdata),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        pcnt_d       = pcnt_q;
        half_d       = half_q;
        frame_done_d = 1'b0;

        if (xfer) begin
            pcnt_d = pcnt_q + 1'b1;
            half_d = ~half_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RUN;
                    wcnt_d  = '0;
                    pcnt_d  = '0;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == LAST_WORD) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (eop_xfer) begin
                    frame_done_d = 1'b1;
                    wcnt_d       = '0;
                    pcnt_d       = '0;
                    state_d      = enable ? ST_RUN : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wcnt_q       <= '0;
            pcnt_q       <= '0;
            half_q       <= 1'b0;
            inflight_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            pcnt_q       <= pcnt_d;
            half_q       <= half_d;
            inflight_q   <= issue;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.mem_chipselect = issue;
    assign bus.mem_address    = issue ? (BASE + wcnt_q) : '0;
    assign bus.mem_write      = 1'b0;
    assign bus.mem_byteenable = 4'hF;
    assign bus.mem_clken      = 1'b1;

    // Data is gated so an empty stream reads as zero, including in reset.
    assign bus.px_valid = !fifo_empty;
    assign bus.px_data  = fifo_empty ? '0 : (half_q ? fifo_head[31:16] : fifo_head[15:0]);
    assign bus.px_sop   = !fifo_empty && (pcnt_q == '0);
    assign bus.px_eop   = !fifo_empty && (pcnt_q == LAST_PIX);

    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_vga_fb_scanout_reader.sv
// Bench for vga_fb_scanout_reader: 4x2 frame, 1-cycle-latency memory model,
// pixel scoreboard derived from memory contents and frame position.
module tb_vga_fb_scanout_reader;
    import vga_pkg::*;

    localparam int W     = 4;
    localparam int H     = 2;
    localparam int BASE  = 'h100;
    localparam int AW    = 16;
    localparam int DEPTH = 4;
    localparam int NPIX  = W * H;
    localparam int NWORD = NPIX / 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic frame_done;

    always #5 clk = ~clk;

    vga_fb_scanout_reader_if #(.ADDR_W(AW)) bus ();

    vga_fb_scanout_reader #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .BASE_ADDR  (BASE),
        .ADDR_W     (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .bus        (bus),
        .frame_done (frame_done)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame memory: 1-cycle read latency, garbage when not selected.
    logic [31:0] mem [NWORD];
    int          mem_off;
    always @(posedge clk) begin
        mem_off = int'(bus.mem_address) - BASE;
        if (bus.mem_chipselect && mem_off >= 0 && mem_off < NWORD)
            bus.mem_readdata <= mem[mem_off];
        else
            bus.mem_readdata <= $urandom;
    end

    // Reference model state, advanced from observed handshakes.
    int          px_idx = 0, exp_word = 0, issued = 0, consumed = 0;
    int          frames = 0, cs_count = 0, pix_count = 0;
    bit          expect_fd = 0, prev_stall = 0;
    rgb565_t     prev_data, m_exp;
    logic        prev_sop, prev_eop;
    logic [31:0] m_word;

    always @(negedge clk) begin
        if (reset) begin
            px_idx = 0; exp_word = 0; issued = 0; consumed = 0;
            expect_fd = 0; prev_stall = 0;
        end else begin
            if (frame_done || expect_fd) chk("frame_done", frame_done, expect_fd);
            if (frame_done) frames++;
            expect_fd = 0;
            if (prev_stall) begin
                chk("hold_valid", bus.px_valid, 1);
                chk("hold_data", bus.px_data, prev_data);
                chk("hold_sop", bus.px_sop, prev_sop);
                chk("hold_eop", bus.px_eop, prev_eop);
            end
            if (bus.mem_chipselect) begin
                cs_count++;
                chk("address", bus.mem_address, BASE + exp_word);
                exp_word = (exp_word + 1) % NWORD;
                issued++;
                chk("fetch_ahead", (issued - consumed) <= DEPTH, 1);
            end
            if (bus.px_valid && bus.px_ready) begin
                m_word = mem[px_idx / 2];
                m_exp  = (px_idx % 2) ? m_word[31:16] : m_word[15:0];
                chk("pixel", bus.px_data, m_exp);
                chk("sop", bus.px_sop, px_idx == 0);
                chk("eop", bus.px_eop, px_idx == NPIX - 1);
                if (px_idx % 2) consumed++;
                if (px_idx == NPIX - 1) expect_fd = 1;
                px_idx = (px_idx + 1) % NPIX;
                pix_count++;
            end
            prev_stall = bus.px_valid && !bus.px_ready;
            prev_data  = bus.px_data;
            prev_sop   = bus.px_sop;
            prev_eop   = bus.px_eop;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outs();
        @(negedge clk);
        chk("rst_valid", bus.px_valid, 0);
        chk("rst_data", bus.px_data, 0);
        chk("rst_sop", bus.px_sop, 0);
        chk("rst_eop", bus.px_eop, 0);
        chk("rst_cs", bus.mem_chipselect, 0);
        chk("rst_addr", bus.mem_address, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_write", bus.mem_write, 0);
        chk("rst_byteen", bus.mem_byteenable, 4'hF);
        chk("rst_clken", bus.mem_clken, 1);
    endtask

    task automatic run_until_pix(input int n, input int budget);
        int c = 0;
        while (px_idx != n && c < budget) begin
            tick();
            c++;
        end
        chk("wait_pixel", px_idx, n);
    endtask

    task automatic wait_frames(input int target, input bit rnd, input int budget);
        int c = 0;
        while (frames < target && c < budget) begin
            bus.px_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            c++;
        end
        chk("frame_count", frames, target);
    endtask

    task automatic drain(input int budget);
        int c = 0;
        int quiet = 0;
        enable = 1'b0;
        while (quiet < 12 && c < budget) begin
            bus.px_ready = 1'b1;
            tick();
            c++;
            if (!bus.px_valid && !bus.mem_chipselect) quiet++;
            else quiet = 0;
        end
        chk("drain_idle", quiet, 12);
        chk("drain_frame_end", px_idx, 0);
    endtask

    int cs_snap, frame_snap, pix_snap;

    initial begin
        bus.px_ready = 1'b1;
        mem[0] = 32'h0002_0001;
        mem[1] = 32'h0004_0003;
        mem[2] = 32'h0006_0005;
        mem[3] = 32'h0008_0007;

        // reset state
        repeat (3) tick();
        check_reset_outs();
        reset = 1'b0;

        // basic frame, enable dropped after pixel 3
        tick();
        enable = 1'b1;
        run_until_pix(3, 100);
        enable = 1'b0;
        wait_frames(1, 0, 100);
        cs_snap = cs_count;
        repeat (15) tick();
        chk("idle_no_reads", cs_count, cs_snap);
        chk("idle_no_valid", bus.px_valid, 0);

        // backpressure mid-frame
        enable = 1'b1;
        run_until_pix(3, 100);
        bus.px_ready = 1'b0;
        repeat (20) tick();
        chk("stall_no_transfer", px_idx, 3);
        chk("stall_valid_held", bus.px_valid, 1);
        bus.px_ready = 1'b1;
        drain(200);
        chk("frames_after_bp", frames, 2);

        // reset mid-frame, then restart
        enable = 1'b1;
        run_until_pix(5, 100);
        reset = 1'b1;
        tick();
        check_reset_outs();
        tick();
        reset = 1'b0;
        chk("no_done_on_abort", frames, 2);
        wait_frames(3, 0, 200);

        // back-to-back frames
        wait_frames(6, 0, 300);
        drain(200);
        chk("frames_b2b", frames, 7);

        // random ready over 10 frames with fresh memory contents
        for (int i = 0; i < NWORD; i++) mem[i] = $urandom;
        frame_snap = frames;
        pix_snap   = pix_count;
        enable = 1'b1;
        wait_frames(frame_snap + 10, 1, 3000);
        drain(300);
        chk("frames_random", frames, frame_snap + 11);
        chk("pixels_random", pix_count - pix_snap, 11 * NPIX);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
